quadrilatero_dispatcher: RTL and testbench

Single-entry issue buffer and hazard scheduler between the XIF issue/commit ports and the three matrix execution units: systolic array (SA), load-store unit (LSU), register-file ops unit (RF, e.g. MZERO). Holds one accepted instruction and waits for a non-killed commit. It then checks matrix-register hazards against each unit's in-flight instruction and hands the instruction to its target unit over a valid/ready handshake. Each unit holds at most one instruction in flight.

---
 rtl/quadrilatero_pkg.sv | 69 ++++++
 rtl/quadrilatero_dispatcher_if.sv | 44 ++++
 rtl/quadrilatero_hazard_check.sv | 33 +++
 rtl/quadrilatero_dispatcher.sv | 147 ++++++++++++++
 tb/tb_quadrilatero_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quadrilatero_pkg.sv
// rtl/quadrilatero_pkg.sv - shared types and register-set helpers for the matrix dispatcher
package quadrilatero_pkg;

    localparam int N_UNITS   = 3;
    localparam int NUM_MREGS = 8;
    localparam int MREG_W    = $clog2(NUM_MREGS);
    localparam int SCALAR_W  = 32;
    localparam int XID_W     = 4;

    typedef logic [MREG_W-1:0]    mreg_t;
    typedef logic [NUM_MREGS-1:0] mset_t;

    typedef enum logic [1:0] {
        UNIT_SA  = 2'd0,
        UNIT_LSU = 2'd1,
        UNIT_RF  = 2'd2
    } unit_e;

    typedef enum logic [2:0] {
        OP_MZERO  = 3'd0,
        OP_MLD_W  = 3'd1,
        OP_MST_W  = 3'd2,
        OP_FMMACC = 3'd3,
        OP_MMACC  = 3'd4
    } op_e;

    typedef struct packed {
        logic [XID_W-1:0]    id;
        op_e                 op;
        mreg_t               md;
        mreg_t               ms1;
        mreg_t               ms2;
        logic [SCALAR_W-1:0] rs1;
        logic [SCALAR_W-1:0] rs2;
    } disp_pkt_t;

    typedef struct packed {
        logic  valid;
        mset_t rd_set;
        mset_t wr_set;
    } inflight_t;

    function automatic mset_t reg_onehot(input mreg_t r);
        mset_t s;
        s    = '0;
        s[r] = 1'b1;
        return s;
    endfunction

    // Stores read md (the data being stored) and write nothing.
    function automatic logic is_store(input op_e op);
        return op == OP_MST_W;
    endfunction

    function automatic mset_t cand_rd_set(input mreg_t md, input mreg_t ms1, input mreg_t ms2,
                                          input logic [1:0] rmask, input logic store);
        mset_t s;
        s = '0;
        if (rmask[0]) s = s | reg_onehot(ms1);
        if (rmask[1]) s = s | reg_onehot(ms2);
        if (store)    s = s | reg_onehot(md);
        return s;
    endfunction

    function automatic mset_t cand_wr_set(input mreg_t md, input logic wr);
        return wr ? reg_onehot(md) : '0;
    endfunction

endpackage

// File: rtl/quadrilatero_dispatcher_if.sv
// rtl/quadrilatero_dispatcher_if.sv - issue/commit/dispatch bundle between XIF, dispatcher and units
interface quadrilatero_dispatcher_if;
    import quadrilatero_pkg::*;

    logic                       issue_valid_i;
    logic                       issue_ready_o;
    logic [XID_W-1:0]           issue_id_i;
    unit_e                      issue_unit_i;
    op_e                        issue_op_i;
    mreg_t                      issue_md_i;
    mreg_t                      issue_ms1_i;
    mreg_t                      issue_ms2_i;
    logic [1:0]                 issue_rmask_i;
    logic                       issue_wr_i;
    logic [SCALAR_W-1:0]        issue_rs1_i;
    logic [SCALAR_W-1:0]        issue_rs2_i;
    logic                       commit_valid_i;
    logic [XID_W-1:0]           commit_id_i;
    logic                       commit_kill_i;
    logic [N_UNITS-1:0]         disp_valid_o;
    logic [N_UNITS-1:0]         disp_ready_i;
    disp_pkt_t                  disp_pkt_o;
    logic [N_UNITS-1:0]         done_i;
    logic                       busy_o;

    modport master (
        output issue_valid_i, issue_id_i, issue_unit_i, issue_op_i,
               issue_md_i, issue_ms1_i, issue_ms2_i, issue_rmask_i, issue_wr_i,
               issue_rs1_i, issue_rs2_i,
               commit_valid_i, commit_id_i, commit_kill_i,
               disp_ready_i, done_i,
        input  issue_ready_o, disp_valid_o, disp_pkt_o, busy_o
    );

    modport slave (
        input  issue_valid_i, issue_id_i, issue_unit_i, issue_op_i,
               issue_md_i, issue_ms1_i, issue_ms2_i, issue_rmask_i, issue_wr_i,
               issue_rs1_i, issue_rs2_i,
               commit_valid_i, commit_id_i, commit_kill_i,
               disp_ready_i, done_i,
        output issue_ready_o, disp_valid_o, disp_pkt_o, busy_o
    );

endinterface

// File: rtl/quadrilatero_hazard_check.sv
// rtl/quadrilatero_hazard_check.sv - RAW/WAW/WAR check of a candidate against in-flight records
module quadrilatero_hazard_check
    import quadrilatero_pkg::*;
(
    input  inflight_t [N_UNITS-1:0] rec_eff,
    input  mreg_t                   md,
    input  mreg_t                   ms1,
    input  mreg_t                   ms2,
    input  logic [1:0]              rmask,
    input  logic                    wr,
    input  logic                    store,
    output logic                    hazard
);

    mset_t src_set;
    mset_t dst_set;

    assign src_set = cand_rd_set(md, ms1, ms2, rmask, store);
    assign dst_set = cand_wr_set(md, wr);

    // Any live unit whose writes overlap our reads/writes, or whose reads overlap our writes, blocks us
    always_comb begin
        hazard = 1'b0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (rec_eff[u].valid &&
                ((|(src_set & rec_eff[u].wr_set)) ||
                 (|(dst_set & (rec_eff[u].wr_set | rec_eff[u].rd_set))))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quadrilatero_dispatcher.sv
// rtl/quadrilatero_dispatcher.sv - single-entry issue buffer and hazard scheduler for SA/LSU/RF
module quadrilatero_dispatcher
    import quadrilatero_pkg::*;
#(
    parameter int N_MREGS = NUM_MREGS,
    parameter int XLEN    = SCALAR_W,
    parameter int ID_W    = XID_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    quadrilatero_dispatcher_if.slave bus
);

    localparam int MW = $clog2(N_MREGS);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [ID_W-1:0]         buf_id_q;
    unit_e                   buf_unit_q;
    op_e                     buf_op_q;
    logic [MW-1:0]           buf_md_q;
    logic [MW-1:0]           buf_ms1_q;
    logic [MW-1:0]           buf_ms2_q;
    logic [1:0]              buf_rmask_q;
    logic                    buf_wr_q;
    logic [XLEN-1:0]         buf_rs1_q;
    logic [XLEN-1:0]         buf_rs2_q;

    inflight_t [N_UNITS-1:0] rec_q;
    inflight_t [N_UNITS-1:0] rec_eff;
    logic [N_UNITS-1:0]      disp_valid;
    logic                    hazard;
    logic                    fire;
    logic                    issue_ready;
    logic                    issue_take;
    logic                    issue_commit_hit;
    logic                    buf_commit_hit;
    mset_t                   new_rd_set;
    mset_t                   new_wr_set;

    // A unit finishing this cycle no longer constrains the buffered instruction
    always_comb begin
        for (int u = 0; u < N_UNITS; u++) begin
            rec_eff[u] = bus.done_i[u] ? '0 : rec_q[u];
        end
    end

    assign new_rd_set = cand_rd_set(buf_md_q, buf_ms1_q, buf_ms2_q, buf_rmask_q, is_store(buf_op_q));
    assign new_wr_set = cand_wr_set(buf_md_q, buf_wr_q);

    quadrilatero_hazard_check u_hazard_check (
        .rec_eff (rec_eff),
        .md      (buf_md_q),
        .ms1     (buf_ms1_q),
        .ms2     (buf_ms2_q),
        .rmask   (buf_rmask_q),
        .wr      (buf_wr_q),
        .store   (is_store(buf_op_q)),
        .hazard  (hazard)
    );

    // Request only the target unit, once committed, hazard-free and that unit is idle
    always_comb begin
        disp_valid = '0;
        if (state_q == ST_READY && !hazard && !rec_eff[buf_unit_q].valid) begin
            disp_valid[buf_unit_q] = 1'b1;
        end
    end

    assign fire             = |(disp_valid & bus.disp_ready_i);
    assign issue_ready      = (state_q == ST_EMPTY) || fire;
    assign issue_take       = bus.issue_valid_i && issue_ready;
    assign issue_commit_hit = bus.commit_valid_i && (bus.commit_id_i == bus.issue_id_i);
    assign buf_commit_hit   = bus.commit_valid_i && (bus.commit_id_i == buf_id_q);

    // Buffer occupancy: a new issue overrides the departing one; commits only match the held id
    always_comb begin
        state_d = state_q;
        if (issue_take) begin
            if (issue_commit_hit) state_d = bus.commit_kill_i ? ST_EMPTY : ST_READY;
            else                  state_d = ST_PEND;
        end else if (fire) begin
            state_d = ST_EMPTY;
        end else if (state_q == ST_PEND && buf_commit_hit) begin
            state_d = bus.commit_kill_i ? ST_EMPTY : ST_READY;
        end
    end

    // State and captured payload
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            buf_id_q    <= '0;
            buf_unit_q  <= UNIT_SA;
            buf_op_q    <= OP_MZERO;
            buf_md_q    <= '0;
            buf_ms1_q   <= '0;
            buf_ms2_q   <= '0;
            buf_rmask_q <= '0;
            buf_wr_q    <= 1'b0;
            buf_rs1_q   <= '0;
            buf_rs2_q   <= '0;
        end else begin
            state_q <= state_d;
            if (issue_take) begin
                buf_id_q    <= bus.issue_id_i;
                buf_unit_q  <= bus.issue_unit_i;
                buf_op_q    <= bus.issue_op_i;
                buf_md_q    <= bus.issue_md_i;
                buf_ms1_q   <= bus.issue_ms1_i;
                buf_ms2_q   <= bus.issue_ms2_i;
                buf_rmask_q <= bus.issue_rmask_i;
                buf_wr_q    <= bus.issue_wr_i;
                buf_rs1_q   <= bus.issue_rs1_i;
                buf_rs2_q   <= bus.issue_rs2_i;
            end
        end
    end

    // In-flight records: done clears, a same-cycle dispatch to that unit reloads and wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rec_q <= '0;
        end else begin
            for (int u = 0; u < N_UNITS; u++) begin
                if (fire && int'(buf_unit_q) == u) begin
                    rec_q[u].valid  <= 1'b1;
                    rec_q[u].rd_set <= new_rd_set;
                    rec_q[u].wr_set <= new_wr_set;
                end else if (bus.done_i[u]) begin
                    rec_q[u] <= '0;
                end
            end
        end
    end

    assign bus.issue_ready_o = issue_ready;
    assign bus.disp_valid_o  = disp_valid;
    assign bus.busy_o        = (state_q != ST_EMPTY) || rec_q[0].valid || rec_q[1].valid || rec_q[2].valid;
    assign bus.disp_pkt_o    = '{id: buf_id_q, op: buf_op_q, md: buf_md_q, ms1: buf_ms1_q,
                                 ms2: buf_ms2_q, rs1: buf_rs1_q, rs2: buf_rs2_q};

endmodule

// File: tb/tb_quadrilatero_dispatcher.sv
// tb/tb_quadrilatero_dispatcher.sv - self-checking bench for quadrilatero_dispatcher
module tb_quadrilatero_dispatcher;
    import quadrilatero_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quadrilatero_dispatcher_if bus();

    quadrilatero_dispatcher #(.N_MREGS(8), .XLEN(32), .ID_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // reference model: 0 empty, 1 waiting for commit, 2 committed
    int        m_state;
    bit [3:0]  m_id;
    int        m_unit;
    op_e       m_op;
    int        m_md, m_ms1, m_ms2;
    bit [1:0]  m_rmask;
    bit        m_wr;
    bit        m_rv [3];
    bit [7:0]  m_rrd [3];
    bit [7:0]  m_rwr [3];
    disp_pkt_t m_pkt;
    bit        e_ready;
    bit [2:0]  e_valid;
    bit        e_busy;
    bit        e_fire;
    bit [7:0]  c_rd, c_wr;

    task automatic model_reset();
        m_state = 0; m_id = 0; m_unit = 0; m_op = OP_MZERO;
        m_md = 0; m_ms1 = 0; m_ms2 = 0; m_rmask = 0; m_wr = 0;
        for (int u = 0; u < 3; u++) begin m_rv[u] = 0; m_rrd[u] = 0; m_rwr[u] = 0; end
        m_pkt = '0;
    endtask

    task automatic model_eval();
        int reads[$];
        int writes[$];
        bit hz;
        if (m_rmask[0]) reads.push_back(m_ms1);
        if (m_rmask[1]) reads.push_back(m_ms2);
        if (m_op == OP_MST_W) reads.push_back(m_md);
        if (m_wr) writes.push_back(m_md);
        c_rd = 0; c_wr = 0;
        foreach (reads[i]) c_rd[reads[i]] = 1'b1;
        foreach (writes[i]) c_wr[writes[i]] = 1'b1;
        hz = 0;
        for (int u = 0; u < 3; u++) begin
            if (m_rv[u] && !bus.done_i[u]) begin
                foreach (reads[i]) if (m_rwr[u][reads[i]]) hz = 1;
                foreach (writes[i]) if (m_rwr[u][writes[i]] || m_rrd[u][writes[i]]) hz = 1;
            end
        end
        e_valid = 0;
        if (m_state == 2 && !hz && !(m_rv[m_unit] && !bus.done_i[m_unit])) e_valid[m_unit] = 1'b1;
        e_fire  = e_valid[m_unit] && bus.disp_ready_i[m_unit];
        e_ready = (m_state == 0) || e_fire;
        e_busy  = (m_state != 0) || m_rv[0] || m_rv[1] || m_rv[2];
    endtask

    task automatic idle();
        bus.issue_valid_i = 0; bus.issue_id_i = 0; bus.issue_unit_i = UNIT_SA; bus.issue_op_i = OP_MZERO;
        bus.issue_md_i = 0; bus.issue_ms1_i = 0; bus.issue_ms2_i = 0; bus.issue_rmask_i = 0;
        bus.issue_wr_i = 0; bus.issue_rs1_i = 0; bus.issue_rs2_i = 0;
        bus.commit_valid_i = 0; bus.commit_id_i = 0; bus.commit_kill_i = 0;
        bus.disp_ready_i = 0; bus.done_i = 0;
    endtask

    // advance one clock, stepping the model with the inputs currently driven
    task automatic tick();
        model_eval();
        for (int u = 0; u < 3; u++) if (bus.done_i[u]) m_rv[u] = 0;
        if (e_fire) begin
            m_rv[m_unit] = 1; m_rrd[m_unit] = c_rd; m_rwr[m_unit] = c_wr;
        end
        if (bus.issue_valid_i && e_ready) begin
            m_id = bus.issue_id_i; m_unit = int'(bus.issue_unit_i); m_op = bus.issue_op_i;
            m_md = int'(bus.issue_md_i); m_ms1 = int'(bus.issue_ms1_i); m_ms2 = int'(bus.issue_ms2_i);
            m_rmask = bus.issue_rmask_i; m_wr = bus.issue_wr_i;
            m_pkt = '{id: bus.issue_id_i, op: bus.issue_op_i, md: bus.issue_md_i, ms1: bus.issue_ms1_i,
                      ms2: bus.issue_ms2_i, rs1: bus.issue_rs1_i, rs2: bus.issue_rs2_i};
            if (bus.commit_valid_i && bus.commit_id_i == bus.issue_id_i) m_state = bus.commit_kill_i ? 0 : 2;
            else m_state = 1;
        end else if (e_fire) begin
            m_state = 0;
        end else if (m_state == 1 && bus.commit_valid_i && bus.commit_id_i == m_id) begin
            m_state = bus.commit_kill_i ? 0 : 2;
        end
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    // kind: 0 SA FMMACC, 1 LSU MLD_W, 2 LSU MST_W, 3 RF MZERO
    task automatic put_issue(input int kind, input logic [3:0] id, input int md, input int ms1, input int ms2);
        bus.issue_valid_i = 1; bus.issue_id_i = id;
        bus.issue_md_i = mreg_t'(md); bus.issue_ms1_i = mreg_t'(ms1); bus.issue_ms2_i = mreg_t'(ms2);
        bus.issue_rs1_i = $urandom; bus.issue_rs2_i = $urandom;
        case (kind)
            0:       begin bus.issue_unit_i = UNIT_SA;  bus.issue_op_i = OP_FMMACC; bus.issue_rmask_i = 2'b11; bus.issue_wr_i = 1; end
            1:       begin bus.issue_unit_i = UNIT_LSU; bus.issue_op_i = OP_MLD_W;  bus.issue_rmask_i = 2'b00; bus.issue_wr_i = 1; end
            2:       begin bus.issue_unit_i = UNIT_LSU; bus.issue_op_i = OP_MST_W;  bus.issue_rmask_i = 2'b00; bus.issue_wr_i = 0; end
            default: begin bus.issue_unit_i = UNIT_RF;  bus.issue_op_i = OP_MZERO;  bus.issue_rmask_i = 2'b00; bus.issue_wr_i = 1; end
        endcase
    endtask

    task automatic put_commit(input logic [3:0] id, input logic kill);
        bus.commit_valid_i = 1; bus.commit_id_i = id; bus.commit_kill_i = kill;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready_o); else passes++;
        checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL reset_disp_valid got %b want 000", bus.disp_valid_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else passes++;
        checks++; if (bus.disp_pkt_o !== '0) $display("FAIL reset_pkt got %h want 0", bus.disp_pkt_o); else passes++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_mzero_latency();
        put_issue(3, 4'h1, 2, 0, 0); put_commit(4'h1, 0);
        #1;
        checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL mzero_accept got %b want 1", bus.issue_ready_o); else passes++;
        tick();
        #1;
        checks++; if (bus.disp_valid_o !== 3'b100) $display("FAIL mzero_valid_t1 got %b want 100", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b111;
        #1;
        checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL mzero_ready_t1 got %b want 1", bus.issue_ready_o); else passes++;
        tick();
        put_issue(2, 4'h2, 2, 0, 0); put_commit(4'h2, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL mzero_wrset_stall got %b want 000", bus.disp_valid_o); else passes++;
            tick();
        end
        bus.done_i = 3'b100;
        #1;
        checks++; if (bus.disp_valid_o !== 3'b010) $display("FAIL mzero_done_bypass got %b want 010", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b010;
        tick();
        bus.done_i = 3'b010;
        tick();
        #1;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL mzero_drained_busy got %b want 0", bus.busy_o); else passes++;
    endtask

    task automatic test_raw_stall();
        put_issue(1, 4'h2, 1, 0, 0); put_commit(4'h2, 0);
        tick();
        bus.disp_ready_i = 3'b010;
        tick();
        put_issue(0, 4'h3, 4, 1, 5); put_commit(4'h3, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL raw_stall got %b want 000", bus.disp_valid_o); else passes++;
            tick();
        end
        bus.done_i = 3'b010;
        #1;
        checks++; if (bus.disp_valid_o !== 3'b001) $display("FAIL raw_release got %b want 001", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b001;
        tick();
        bus.done_i = 3'b001;
        tick();
    endtask

    task automatic test_war_store();
        put_issue(0, 4'h4, 6, 3, 3); put_commit(4'h4, 0);
        tick();
        bus.disp_ready_i = 3'b001;
        tick();
        put_issue(2, 4'h5, 3, 0, 0); put_commit(4'h5, 0);
        tick();
        #1;
        checks++; if (bus.disp_valid_o !== 3'b010) $display("FAIL store_read_read got %b want 010", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b010;
        tick();
        bus.done_i = 3'b010;
        tick();
        put_issue(1, 4'h6, 3, 0, 0); put_commit(4'h6, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL war_stall got %b want 000", bus.disp_valid_o); else passes++;
            tick();
        end
        bus.done_i = 3'b001;
        #1;
        checks++; if (bus.disp_valid_o !== 3'b010) $display("FAIL war_release got %b want 010", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b010;
        tick();
        bus.done_i = 3'b010;
        tick();
    endtask

    task automatic test_kill();
        put_issue(0, 4'h5, 1, 2, 3);
        tick();
        tick();
        put_commit(4'h5, 1);
        #1;
        checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL kill_no_valid got %b want 000", bus.disp_valid_o); else passes++;
        tick();
        #1;
        checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL kill_issue_ready got %b want 1", bus.issue_ready_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL kill_busy got %b want 0", bus.busy_o); else passes++;
        put_issue(0, 4'h9, 1, 2, 3); put_commit(4'h9, 1);
        tick();
        #1;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL same_cycle_kill_busy got %b want 0", bus.busy_o); else passes++;
        checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL same_cycle_kill_valid got %b want 000", bus.disp_valid_o); else passes++;
    endtask

    task automatic test_nonmatch_commit();
        put_issue(0, 4'h5, 2, 3, 4);
        tick();
        put_commit(4'h7, 0);
        tick();
        #1;
        checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL nonmatch_valid got %b want 000", bus.disp_valid_o); else passes++;
        checks++; if (bus.issue_ready_o !== 1'b0) $display("FAIL nonmatch_ready got %b want 0", bus.issue_ready_o); else passes++;
        put_commit(4'h5, 0);
        tick();
        #1;
        checks++; if (bus.disp_valid_o !== 3'b001) $display("FAIL match_dispatch got %b want 001", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b001;
        tick();
        bus.done_i = 3'b001;
        tick();
    endtask

    task automatic test_reset_mid();
        put_issue(1, 4'h1, 1, 0, 0); put_commit(4'h1, 0);
        tick();
        bus.disp_ready_i = 3'b010;
        tick();
        put_issue(3, 4'h2, 5, 0, 0); put_commit(4'h2, 0);
        tick();
        #1;
        rst = 1;
        #1;
        checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL midrst_issue_ready got %b want 1", bus.issue_ready_o); else passes++;
        checks++; if (bus.disp_valid_o !== 3'b000) $display("FAIL midrst_valid got %b want 000", bus.disp_valid_o); else passes++;
        checks++; if (bus.busy_o !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy_o); else passes++;
        checks++; if (bus.disp_pkt_o !== '0) $display("FAIL midrst_pkt got %h want 0", bus.disp_pkt_o); else passes++;
        model_reset();
        @(negedge clk);
        rst = 0;
        put_issue(1, 4'h3, 1, 0, 0); put_commit(4'h3, 0);
        tick();
        #1;
        checks++; if (bus.disp_valid_o !== 3'b010) $display("FAIL postrst_dispatch got %b want 010", bus.disp_valid_o); else passes++;
        bus.disp_ready_i = 3'b010;
        tick();
        bus.done_i = 3'b010;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 1) == 1)
                put_issue($urandom_range(0, 3), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 4) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: bus.commit_id_i = m_id;
                    5, 6, 7:       bus.commit_id_i = bus.issue_id_i;
                    default:       bus.commit_id_i = 4'($urandom_range(0, 15));
                endcase
                bus.commit_valid_i = 1;
                bus.commit_kill_i  = ($urandom_range(0, 3) == 0);
            end
            for (int u = 0; u < 3; u++) begin
                bus.disp_ready_i[u] = ($urandom_range(0, 9) < 7);
                bus.done_i[u] = m_rv[u] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            end
            #1;
            model_eval();
            checks++; if (bus.issue_ready_o !== e_ready) $display("FAIL rnd_issue_ready cyc %0d got %b want %b", cyc, bus.issue_ready_o, e_ready); else passes++;
            checks++; if (bus.disp_valid_o !== e_valid) $display("FAIL rnd_disp_valid cyc %0d got %b want %b", cyc, bus.disp_valid_o, e_valid); else passes++;
            checks++; if (bus.busy_o !== e_busy) $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, bus.busy_o, e_busy); else passes++;
            checks++; if (bus.disp_pkt_o !== m_pkt) $display("FAIL rnd_pkt cyc %0d got %h want %h", cyc, bus.disp_pkt_o, m_pkt); else passes++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mzero_latency();
        test_raw_stall();
        test_war_store();
        test_kill();
        test_nonmatch_commit();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
